// File: rtl/seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : seq_pkg                                                       |
// | Description: Shared parameter defaults for the sequence-match logger and   |
// |              the state encodings of the upstream sequence detector.        |
// | Contents   : TS_W_DEF, DEPTH_DEF, CNT_W_DEF, det_state_t                   |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
package seq_pkg;

  // Parameter defaults picked up by the logger, its FIFO and its interface.
  localparam int TS_W_DEF  = 16;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 8;

  // Upstream detector states; the detector raises det_i for one cycle when
  // it reaches DET_HIT.
  typedef enum logic [2:0] {
    DET_IDLE = 3'd0,
    DET_S1   = 3'd1,
    DET_S2   = 3'd2,
    DET_S3   = 3'd3,
    DET_HIT  = 3'd4
  } det_state_t;

endpackage : seq_pkg
`default_nettype wire

// File: rtl/seq_match_logger_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface  : seq_match_logger_if                                           |
// | Description: Valid/ready event stream carrying the timestamp at the head   |
// |              of the logger queue.                                          |
// | Signals    : ev_valid_o  head holds a valid event (logger -> consumer)     |
// |              ev_ready_i  consumer accepts the head (consumer -> logger)    |
// |              ev_ts_o     timestamp of the head event, 0 when empty         |
// | Modports   : master = logger side, slave = consumer side                   |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
interface seq_match_logger_if
  import seq_pkg::*;
#(
  parameter int TS_W = TS_W_DEF
);

  logic            ev_valid_o;
  logic            ev_ready_i;
  logic [TS_W-1:0] ev_ts_o;

  modport master (
    output ev_valid_o,
    output ev_ts_o,
    input  ev_ready_i
  );

  modport slave (
    input  ev_valid_o,
    input  ev_ts_o,
    output ev_ready_i
  );

endinterface : seq_match_logger_if
`default_nettype wire

// File: rtl/seq_ts_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : seq_ts_fifo                                                   |
// | Description: Synchronous first-word-fall-through FIFO holding event        |
// |              timestamps. The head entry is visible on dout without a pop.  |
// | Ports      : clk, rst_n (async, active-low)                                |
// |              clr   synchronous flush, overrides push and pop               |
// |              push  write din (accepted when not full, or full with pop)    |
// |              pop   retire the head (ignored when empty)                    |
// |              dout  head entry, reads 0 when empty                          |
// |              full, empty, level (occupancy 0..DEPTH)                       |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module seq_ts_fifo
  import seq_pkg::*;
#(
  parameter int WIDTH = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_LVL);

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with a pop. Flush wins over both.
  assign do_pop  = pop & ~empty & ~clr;
  assign do_push = push & (~full | do_pop) & ~clr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: every read is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = empty ? '0 : mem[rd_ptr];
  assign level = count;

endmodule : seq_ts_fifo
`default_nettype wire

// File: rtl/seq_match_logger.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : seq_match_logger                                              |
// | Description: Timestamps single-cycle match pulses from a sequence          |
// |              detector and queues them for a valid/ready consumer. Counts   |
// |              all detections (saturating) and flags dropped events.         |
// | Ports      : clk, rst_n (async, active-low)                                |
// |              det_i        match pulse                                      |
// |              en_i         logging enable (gates ts counter and capture)    |
// |              clr_i        synchronous clear of queue, counters and flags   |
// |              ev           event stream (seq_match_logger_if.master)        |
// |              match_cnt_o  saturating count of detections                   |
// |              ovf_o        sticky drop flag                                 |
// |              level_o      queue occupancy                                  |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module seq_match_logger
  import seq_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   det_i,
  input  logic                   en_i,
  input  logic                   clr_i,
  seq_match_logger_if.master     ev,
  output logic [CNT_W-1:0]       match_cnt_o,
  output logic                   ovf_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] head_ts;
  logic            capture;
  logic            pop;
  logic            drop;
  logic            full;
  logic            empty;

  assign capture = det_i & en_i;
  assign pop     = ~empty & ev.ev_ready_i;
  // A full queue only loses the event when the consumer is not freeing a
  // slot in the same cycle.
  assign drop    = capture & full & ~pop;

  // Free-running timestamp; the value captured is the pre-increment one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts <= '0;
    end else if (clr_i) begin
      ts <= '0;
    end else if (en_i) begin
      ts <= ts + 1'b1;
    end
  end

  // Every detection counts, including dropped ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt_o <= '0;
    end else if (clr_i) begin
      match_cnt_o <= '0;
    end else if (capture && (match_cnt_o != CNT_MAX)) begin
      match_cnt_o <= match_cnt_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_o <= 1'b0;
    end else if (clr_i) begin
      ovf_o <= 1'b0;
    end else if (drop) begin
      ovf_o <= 1'b1;
    end
  end

  seq_ts_fifo #(
    .WIDTH (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_i),
    .push  (capture),
    .pop   (ev.ev_ready_i),
    .din   (ts),
    .dout  (head_ts),
    .full  (full),
    .empty (empty),
    .level (level_o)
  );

  assign ev.ev_valid_o = ~empty;
  assign ev.ev_ts_o    = head_ts;

endmodule : seq_match_logger
`default_nettype wire

// File: tb/tb_seq_match_logger.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_seq_match_logger                                           |
// | Description: Directed and randomized bench for seq_match_logger, checked   |
// |              cycle by cycle against a queue-based reference model.         |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_seq_match_logger;

  localparam int TS_W  = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic det, en, clr;
  logic [CNT_W-1:0] match_cnt;
  logic             ovf;
  logic [2:0]       level;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int q[$];
  int m_ts;
  int m_cnt;
  int m_ovf;

  seq_match_logger_if #(.TS_W(TS_W)) ev_if ();

  seq_match_logger #(
    .TS_W  (TS_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .det_i       (det),
    .en_i        (en),
    .clr_i       (clr),
    .ev          (ev_if),
    .match_cnt_o (match_cnt),
    .ovf_o       (ovf),
    .level_o     (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("ev_valid", 32'(ev_if.ev_valid_o), 32'(q.size() != 0));
    check("ev_ts",    32'(ev_if.ev_ts_o),    (q.size() != 0) ? 32'(q[0]) : 32'd0);
    check("level",    32'(level),            32'(q.size()));
    check("match_cnt",32'(match_cnt),        32'(m_cnt));
    check("ovf",      32'(ovf),              32'(m_ovf));
    check("ts",       32'(dut.ts),           32'(m_ts));
  endtask

  task automatic model_reset();
    q.delete();
    m_ts  = 0;
    m_cnt = 0;
    m_ovf = 0;
  endtask

  // One clock of the logger's rules, applied to the model.
  task automatic model_update(input logic d, input logic e, input logic c, input logic r);
    if (c) begin
      model_reset();
    end else begin
      if (r && q.size() != 0) void'(q.pop_front());
      if (d && e) begin
        if (q.size() < DEPTH) q.push_back(m_ts);
        else m_ovf = 1;
        if (m_cnt < CMAX) m_cnt++;
      end
      if (e) m_ts = (m_ts + 1) % (1 << TS_W);
    end
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic step(input logic d, input logic e, input logic c, input logic r);
    det = d; en = e; clr = c; ev_if.ev_ready_i = r;
    @(negedge clk);
    check_all();
    model_update(d, e, c, r);
    @(posedge clk);
    #1;
  endtask

  int ts_hold;

  initial begin
    rst_n = 1'b0;
    det = 1'b0; en = 1'b0; clr = 1'b0; ev_if.ev_ready_i = 1'b0;
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single capture at ts=5, consumer always ready
    for (int k = 0; k < 20 && m_ts != 5; k++) step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("req033_valid", 32'(ev_if.ev_valid_o), 32'd1);
    check("req033_ts",    32'(ev_if.ev_ts_o),    32'd5);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("req033_level", 32'(level), 32'd0);

    // Overflow: five captures into a four-deep queue with no consumer
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 20 && m_ts <= 10; k++)
      step(m_ts inside {2, 4, 6, 8, 10}, 1'b1, 1'b0, 1'b0);
    check("req034_level", 32'(level),     32'd4);
    check("req034_ovf",   32'(ovf),       32'd1);
    check("req034_cnt",   32'(match_cnt), 32'd5);
    for (int i = 0; i < 4; i++) begin
      check("req034_drain", 32'(ev_if.ev_ts_o), 32'(2 * (i + 1)));
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    check("req034_empty", 32'(ev_if.ev_valid_o), 32'd0);

    // Full queue with simultaneous capture and pop
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 30 && m_ts != 20; k++)
      step(m_ts inside {1, 2, 3, 4}, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("req035_level", 32'(level), 32'd4);
    check("req035_ovf",   32'(ovf),   32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("req035_tail", 32'(ev_if.ev_ts_o), 32'd20);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Clear wins over a same-cycle capture and pop
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("req037_level", 32'(level),            32'd0);
    check("req037_valid", 32'(ev_if.ev_valid_o), 32'd0);
    check("req037_cnt",   32'(match_cnt),        32'd0);
    check("req037_ovf",   32'(ovf),              32'd0);
    check("req037_ts",    32'(dut.ts),           32'd0);

    // Disabled logging ignores detections and freezes ts
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    ts_hold = m_ts;
    for (int i = 0; i < 10; i++) step(1'($urandom % 2), 1'b0, 1'b0, 1'b0);
    check("req038_ts_frozen", 32'(dut.ts),    32'(ts_hold));
    check("req038_no_cap",    32'(match_cnt), 32'd0);

    // Counter saturation
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    check("req036_sat", 32'(match_cnt), 32'd255);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    check("req036_hold", 32'(match_cnt), 32'd255);

    // Randomized traffic
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 600; i++)
      step(1'($urandom % 2), 1'($urandom % 4 != 0), 1'($urandom % 60 == 0), 1'($urandom % 3 == 0));

    // Asynchronous reset with two events queued
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("pre_rst_level", 32'(level), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    det = 1'b0; en = 1'b0; clr = 1'b0; ev_if.ev_ready_i = 1'b0;
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("req029_first_ts", 32'(ev_if.ev_ts_o), 32'd3);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_seq_match_logger
`default_nettype wire

// File: doc/seq_match_logger.md
SEQ_MATCH_LOGGER -- requirements
Module: seq_match_logger

Interface
REQ-001 The block SHALL take parameter TS_W, default 16, as the timestamp width in bits.
REQ-002 The block SHALL take parameter DEPTH, default 4, as the event queue depth (power of two, >=2).
REQ-003 The block SHALL take parameter CNT_W, default 8, as the match counter width in bits.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 det_i  input  1  single-cycle match pulse from the upstream sequence detector.
REQ-007 en_i  input  1  logging enable; gates the timestamp counter and event capture.
REQ-008 clr_i  input  1  synchronous clear of queue, counters and flags.
REQ-009 ev_valid_o  output  1  queue head holds a valid event.
REQ-010 ev_ready_i  input  1  consumer accepts the head event.
REQ-011 ev_ts_o  output  TS_W  timestamp of the head event.
REQ-012 match_cnt_o  output  CNT_W  total accepted-or-dropped detections, saturating.
REQ-013 ovf_o  output  1  sticky flag: at least one event was dropped.
REQ-014 level_o  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-015 A free-running counter ts SHALL increment by 1 each cycle en_i=1, wrap from 2^TS_W-1 to 0, and hold when en_i=0.
REQ-016 A capture SHALL occur in cycle N when det_i=1 and en_i=1; det_i with en_i=0 SHALL be ignored.
REQ-017 The captured timestamp SHALL be the ts value present in cycle N (before that cycle's increment).
REQ-018 Capture in cycle N SHALL make ev_valid_o=1 at cycle N+1 when the queue was empty (1-cycle latency).
REQ-019 The queue SHALL be first-word-fall-through: ev_valid_o = (level_o != 0), ev_ts_o = oldest entry.
REQ-020 A pop SHALL occur on ev_valid_o=1 and ev_ready_i=1; ev_ts_o SHALL remain stable while ev_valid_o=1 and ev_ready_i=0.
REQ-021 Capture with queue full and no pop SHALL drop the event and set ovf_o=1 at the next edge.
REQ-022 Capture with queue full and a simultaneous pop SHALL be accepted; level_o unchanged, no overflow.
REQ-023 Capture and pop together on a non-full, non-empty queue SHALL leave level_o unchanged.
REQ-024 match_cnt_o SHALL increment on every capture (including dropped ones) and saturate at 2^CNT_W-1.
REQ-025 ovf_o SHALL remain set until clr_i or reset.
REQ-026 clr_i=1 SHALL, at the next edge, empty the queue and zero ts, match_cnt_o and ovf_o; a capture or pop in the same cycle SHALL be discarded (clr_i has priority).
REQ-027 ev_ts_o SHALL read 0 when the queue is empty.

Reset
REQ-028 rst_n=0 SHALL immediately force ev_valid_o=0, ev_ts_o=0, match_cnt_o=0, ovf_o=0, level_o=0, ts=0, regardless of clk.
REQ-029 Reset asserted mid-operation SHALL discard all queued events; the first capture after release SHALL carry the ts value of that cycle, counted from 0.

Structure
REQ-030 Parameter defaults SHALL reside in shared package seq_pkg alongside the detector state encodings.
REQ-031 Queue storage and pointers SHALL be a sub-module seq_ts_fifo (synchronous FWFT FIFO, push/pop/full/empty/level).
REQ-032 Timestamp counter, match counter and overflow flag SHALL reside in the top-level module.

Verification
REQ-033 Reset, en_i=1, det_i pulse at ts=5, ev_ready_i=1 -> ev_valid_o=1 next cycle with ev_ts_o=5, popped; level_o returns to 0.
REQ-034 ev_ready_i=0, five det_i pulses at ts=2,4,6,8,10 -> level_o=4, ovf_o=1, match_cnt_o=5; draining yields 2,4,6,8.
REQ-035 Queue full, det_i and ev_ready_i both 1 at ts=20 -> no overflow, level_o stays 4, ts=20 becomes the tail entry.
REQ-036 CNT_W=8, 300 captures with ev_ready_i=1 -> match_cnt_o=255 and holds.
REQ-037 clr_i and det_i together with 3 queued events -> next cycle level_o=0, ev_valid_o=0, match_cnt_o=0, ovf_o=0, ts=0.
REQ-038 en_i=0 for 10 cycles with det_i pulses -> ts frozen, no captures; rst_n pulse with 2 events queued -> all outputs 0 asynchronously.
